// File: rtl/hilo_mult_ctrl.sv
// Operand/result sequencer around a combinational 32x32 multiplier: holds operands
// for LATENCY cycles, then captures the product into HI/LO. Optional macro: MULT_SIGNED_EN.
module hilo_mult_ctrl #(
  parameter int LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
`ifdef MULT_SIGNED_EN
  input  logic        signed_op,
`endif
  output logic [31:0] mult_in1,
  output logic [31:0] mult_in2,
  input  logic [63:0] mult_out,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        dbg_state
);

  localparam int CW = $clog2(LATENCY + 1);

  // Handshake: start is taken only on an edge where busy is low; the issuer
  // must hold off while busy=1, and done marks the edge HI/LO were captured.
  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic [31:0]     r_in1, r_in2, r_hi, r_lo;
  logic [31:0]     w_in1_nxt, w_in2_nxt, w_hi_nxt, w_lo_nxt;
  logic            r_busy, r_done, w_busy_nxt, w_done_nxt;
  logic [31:0]     w_opa_sel, w_opb_sel;
  logic [63:0]     w_prod;

`ifdef MULT_SIGNED_EN
  logic r_neg;
  logic w_neg_in;

  // The multiplier is unsigned: feed magnitudes and fix the sign at capture.
  assign w_neg_in  = signed_op & (op_a[31] ^ op_b[31]);
  assign w_opa_sel = (signed_op && op_a[31]) ? (32'd0 - op_a) : op_a;
  assign w_opb_sel = (signed_op && op_b[31]) ? (32'd0 - op_b) : op_b;
  assign w_prod    = r_neg ? (64'd0 - mult_out) : mult_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_neg <= 1'b0;
    end else if (r_state == ST_IDLE && start) begin
      r_neg <= w_neg_in;
    end
  end
`else
  assign w_opa_sel = op_a;
  assign w_opb_sel = op_b;
  assign w_prod    = mult_out;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_in1   <= '0;
      r_in2   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_in1   <= w_in1_nxt;
      r_in2   <= w_in2_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_in1_nxt   = r_in1;
    w_in2_nxt   = r_in2;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_in1_nxt   = w_opa_sel;
          w_in2_nxt   = w_opb_sel;
          w_cnt_nxt   = CW'(LATENCY - 1);
          w_busy_nxt  = 1'b1;
          w_state_nxt = ST_BUSY;
        end else begin
          if (mthi) w_hi_nxt = wdata;
          if (mtlo) w_lo_nxt = wdata;
        end
      end
      ST_BUSY: begin
        // Operands stay frozen so the multicycle path through the multiplier holds.
        if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end else begin
          w_hi_nxt    = w_prod[63:32];
          w_lo_nxt    = w_prod[31:0];
          w_done_nxt  = 1'b1;
          w_busy_nxt  = 1'b0;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign mult_in1  = r_in1;
  assign mult_in2  = r_in2;
  assign hi        = r_hi;
  assign lo        = r_lo;
  assign busy      = r_busy;
  assign done      = r_done;
  assign dbg_state = (r_state == ST_BUSY);

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Bench for hilo_mult_ctrl: two instances (LATENCY 4 and 1) sharing one stimulus
// stream, each with a cycle-level reference model and a done-driven scoreboard.
module tb_hilo_mult_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        signed_op = 1'b0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                           input logic s);
    if (s) return 64'(longint'($signed(a)) * longint'($signed(b)));
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [31:0] ref_mag(input logic [31:0] v, input logic s);
    return (s && v[31]) ? (32'd0 - v) : v;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_lat
    localparam int LAT = (k == 0) ? 4 : 1;

    logic [31:0] w_in1, w_in2, w_hi, w_lo;
    logic [63:0] w_mout;
    logic        w_busy, w_done, w_dbg;

    assign w_mout = {32'd0, w_in1} * {32'd0, w_in2};

    hilo_mult_ctrl #(.LATENCY(LAT)) u_dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .op_a     (op_a),
      .op_b     (op_b),
`ifdef MULT_SIGNED_EN
      .signed_op(signed_op),
`endif
      .mult_in1 (w_in1),
      .mult_in2 (w_in2),
      .mult_out (w_mout),
      .mthi     (mthi),
      .mtlo     (mtlo),
      .wdata    (wdata),
      .hi       (w_hi),
      .lo       (w_lo),
      .busy     (w_busy),
      .done     (w_done),
      .dbg_state(w_dbg)
    );

    // Reference: m_rem = cycles left until capture; 0 means idle.
    int          m_rem = 0;
    logic [31:0] m_hi = '0, m_lo = '0, m_in1 = '0, m_in2 = '0;
    logic        m_done = 1'b0;
    logic [63:0] m_prod = '0;
    logic [63:0] exp_q[$];

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        m_rem = 0; m_hi = '0; m_lo = '0; m_in1 = '0; m_in2 = '0;
        m_done = 1'b0; m_prod = '0;
        exp_q.delete();
      end else begin
        m_done = 1'b0;
        if (m_rem == 0) begin
          if (start) begin
            m_in1  = ref_mag(op_a, signed_op);
            m_in2  = ref_mag(op_b, signed_op);
            m_prod = ref_prod(op_a, op_b, signed_op);
            m_rem  = LAT;
            exp_q.push_back(m_prod);
          end else begin
            if (mthi) m_hi = wdata;
            if (mtlo) m_lo = wdata;
          end
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            {m_hi, m_lo} = m_prod;
            m_done = 1'b1;
          end
        end
      end
    end

    always @(negedge clk) begin
      check($sformatf("L%0d busy", LAT), 64'(w_busy), 64'(m_rem != 0));
      check($sformatf("L%0d state", LAT), 64'(w_dbg), 64'(m_rem != 0));
      check($sformatf("L%0d done", LAT), 64'(w_done), 64'(m_done));
      check($sformatf("L%0d hi", LAT), 64'(w_hi), 64'(m_hi));
      check($sformatf("L%0d lo", LAT), 64'(w_lo), 64'(m_lo));
      check($sformatf("L%0d mult_in1", LAT), 64'(w_in1), 64'(m_in1));
      check($sformatf("L%0d mult_in2", LAT), 64'(w_in2), 64'(m_in2));
    end

    always @(negedge clk) begin
      if (w_done) begin
        check($sformatf("L%0d pending on done", LAT), 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) check($sformatf("L%0d product", LAT), {w_hi, w_lo}, exp_q.pop_front());
      end
    end
  end

  task automatic drive(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input logic mh, input logic ml, input logic [31:0] wd,
                       input logic so);
    start = s; op_a = a; op_b = b; mthi = mh; mtlo = ml; wdata = wd;
`ifdef MULT_SIGNED_EN
    signed_op = so;
`else
    signed_op = 1'b0;
    if (so) begin end
`endif
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  function automatic logic [31:0] pick_op();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1 rst = 1'b1;
    @(posedge clk); #2;
    check("reset hi", 64'(g_lat[0].w_hi), 64'd0);
    check("reset mult_in1", 64'(g_lat[0].w_in1), 64'd0);
    rst = 1'b0;

    drive(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, '0, 1'b0);
    idle(3);
    check("max busy held", 64'(g_lat[0].w_busy), 64'd1);
    idle(1);
    check("max hi", 64'(g_lat[0].w_hi), 64'hFFFFFFFE);
    check("max lo", 64'(g_lat[0].w_lo), 64'h1);
    check("max done", 64'(g_lat[0].w_done), 64'd1);

    drive(1'b1, 32'd7, 32'd9, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 32'd2, 32'd3, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    check("ignored start busy", 64'(g_lat[0].w_busy), 64'd1);
    idle(1);
    check("7x9 lo", 64'(g_lat[0].w_lo), 64'h3F);
    check("7x9 hi", 64'(g_lat[0].w_hi), 64'h0);
    drive(1'b1, 32'd5, 32'd6, 1'b0, 1'b0, '0, 1'b0);
    check("b2b busy", 64'(g_lat[0].w_busy), 64'd1);
    idle(4);

    drive(1'b0, '0, '0, 1'b1, 1'b0, 32'h12345678, 1'b0);
    check("mthi idle", 64'(g_lat[0].w_hi), 64'h12345678);
    drive(1'b1, 32'd3, 32'd4, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b0, '0, '0, 1'b0, 1'b1, 32'hDEAD, 1'b0);
    check("mtlo busy ignored", 64'(g_lat[0].w_lo), 64'h1E);
    drive(1'b0, '0, '0, 1'b1, 1'b1, 32'hBEEF, 1'b0);
    check("capture over mtlo", 64'(g_lat[0].w_lo), 64'hC);

    drive(1'b1, 32'h10000, 32'h10000, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
    check("L1 hi", 64'(g_lat[1].w_hi), 64'h1);
    check("L1 lo", 64'(g_lat[1].w_lo), 64'h0);
    idle(4);

`ifdef MULT_SIGNED_EN
    drive(1'b1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, '0, 1'b1);
    idle(4);
    check("signed hi", 64'(g_lat[0].w_hi), 64'hFFFFFFFF);
    check("signed lo", 64'(g_lat[0].w_lo), 64'hFFFFFFFA);
    drive(1'b1, 32'hFFFFFFFE, 32'd3, 1'b0, 1'b0, '0, 1'b0);
    idle(4);
    check("unsigned hi", 64'(g_lat[0].w_hi), 64'h2);
    check("unsigned lo", 64'(g_lat[0].w_lo), 64'hFFFFFFFA);
`endif

    drive(1'b1, 32'hABCD, 32'h1234, 1'b0, 1'b0, '0, 1'b0);
    idle(2);
    rst = 1'b1;
    #1;
    check("midbusy rst busy", 64'(g_lat[0].w_busy), 64'd0);
    check("midbusy rst hi", 64'(g_lat[0].w_hi), 64'd0);
    check("midbusy rst in2", 64'(g_lat[0].w_in2), 64'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    idle(5);

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(0, 2) == 0, pick_op(), pick_op(),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom,
            1'($urandom_range(0, 1)));
    end
    idle(8);
    check("L4 queue drained", 64'(g_lat[0].exp_q.size()), 64'd0);
    check("L1 queue drained", 64'(g_lat[1].exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
